seq_detector_param: RTL and testbench

Runtime-configurable serial pattern detector with a Moore-style registered output.
- Pattern bits, pattern length (1..PAT_W) and overlap/non-overlap mode are loaded through a config strobe.
- Sits on a 1-bit sampled data stream with a valid qualifier and drives a one-cycle match pulse per detected occurrence.
- Reset defaults make it a drop-in overlapping "1101" detector.

---
 rtl/seq_det_pkg.sv | 29 ++
 rtl/seq_det_history.sv | 42 ++++
 rtl/seq_detector_param.sv | 127 ++++++++++++
 tb/tb_seq_detector_param.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared state type and helpers for the serial pattern detector
package seq_det_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HUNT = 2'd1,
    ST_HIT  = 2'd2
  } state_t;

  // Widest compare the helper supports; PAT_W must stay below this.
  localparam int CMP_W = 64;

  function automatic int len_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

  function automatic int clamp_len(input int len, input int max_len);
    return (len > max_len) ? max_len : len;
  endfunction

  function automatic logic masked_eq(input logic [CMP_W-1:0] pattern,
                                     input logic [CMP_W-1:0] hist,
                                     input int               len);
    logic [CMP_W-1:0] mask;
    mask = (len >= CMP_W) ? '1 : ((CMP_W'(1) << len) - CMP_W'(1));
    return ((pattern ^ hist) & mask) == '0;
  endfunction

endpackage

// File: rtl/seq_det_history.sv
// rtl/seq_det_history.sv - serial history shift register with saturating fill count
module seq_det_history
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_shift,
  input  logic             i_din,
  input  logic             i_clear,
  input  logic             i_flush,
  output logic [PAT_W-1:0] o_hist,
  output logic [LEN_W-1:0] o_fill
);

  logic [PAT_W-1:0] r_hist;
  logic [LEN_W-1:0] r_fill;

  // Flush only restarts the fill count; the shifted-in bit is still kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_clear) begin
      r_hist <= '0;
      r_fill <= '0;
    end else begin
      if (i_shift)
        r_hist <= {r_hist[PAT_W-2:0], i_din};
      if (i_flush)
        r_fill <= '0;
      else if (i_shift && (r_fill != LEN_W'(PAT_W)))
        r_fill <= r_fill + LEN_W'(1);
    end
  end

  assign o_hist = r_hist;
  assign o_fill = r_fill;

endmodule

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - runtime-configurable serial pattern detector, Moore match pulse
// Define MATCH_COUNT_EN to build the saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W       = 8,
  parameter logic [PAT_W-1:0] RST_PATTERN = 8'b0000_1101,
  parameter int               RST_LEN     = 4,
  parameter bit               RST_OVERLAP = 1'b1,
  parameter int               CNT_W       = 16,
  localparam int              LEN_W       = len_w(PAT_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             din_valid,
  input  logic             din,
  output logic             match,
  output logic             armed,
  output logic [CNT_W-1:0] match_count
);

  localparam logic [LEN_W-1:0] RST_LEN_C = LEN_W'(clamp_len(RST_LEN, PAT_W));
  localparam state_t           RST_STATE = (RST_LEN_C == '0) ? ST_IDLE : ST_HUNT;

  logic [PAT_W-1:0] r_pattern;
  logic [LEN_W-1:0] r_len;
  logic             r_overlap;
  state_t           r_state;
  logic             r_match;
  logic             r_armed;

  logic [PAT_W-1:0] w_hist;
  logic [LEN_W-1:0] w_fill;
  logic [LEN_W-1:0] w_load_len;
  logic             w_accept;
  logic             w_hit;
  logic             w_take_hit;

  assign w_load_len = LEN_W'(clamp_len(int'(cfg_len), PAT_W));
  assign w_accept   = din_valid && !cfg_load;
  // The incoming bit completes the window, so compare against {hist, din}.
  assign w_hit      = ((int'(w_fill) + 1) >= int'(r_len)) &&
                      masked_eq({{(CMP_W-PAT_W){1'b0}}, r_pattern},
                                {{(CMP_W-PAT_W-1){1'b0}}, w_hist, din},
                                int'(r_len));
  assign w_take_hit = w_accept && w_hit && (r_state != ST_IDLE);

  seq_det_history #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_history (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_shift (w_accept),
    .i_din   (din),
    .i_clear (cfg_load),
    .i_flush (w_take_hit && !r_overlap),
    .o_hist  (w_hist),
    .o_fill  (w_fill)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pattern <= RST_PATTERN;
      r_len     <= RST_LEN_C;
      r_overlap <= RST_OVERLAP;
      r_state   <= RST_STATE;
      r_match   <= 1'b0;
      r_armed   <= (RST_STATE != ST_IDLE);
    end else if (cfg_load) begin
      r_pattern <= cfg_pattern;
      r_len     <= w_load_len;
      r_overlap <= cfg_overlap;
      r_match   <= 1'b0;
      if (w_load_len == '0) begin
        r_state <= ST_IDLE;
        r_armed <= 1'b0;
      end else begin
        r_state <= ST_HUNT;
        r_armed <= 1'b1;
      end
    end else begin
      case (r_state)
        ST_IDLE: r_match <= 1'b0;
        ST_HUNT, ST_HIT: begin
          if (w_take_hit) begin
            r_state <= ST_HIT;
            r_match <= 1'b1;
          end else begin
            r_state <= ST_HUNT;
            r_match <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_match <= 1'b0;
          r_armed <= 1'b0;
        end
      endcase
    end
  end

  assign match = r_match;
  assign armed = r_armed;

`ifdef MATCH_COUNT_EN
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_count <= '0;
    else if (cfg_load)
      r_count <= '0;
    else if (w_take_hit && (r_count != '1))
      r_count <= r_count + CNT_W'(1);
  end

  assign match_count = r_count;
`else
  assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - scoreboard bench for seq_detector_param
// Counter expectations follow MATCH_COUNT_EN.
module tb_seq_detector_param;

`ifdef MATCH_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif
  localparam int CNT_MAX = 3;

  logic       clk;
  logic       rst_n;
  logic       cfg_load;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       din_valid;
  logic       din;
  logic       match;
  logic       armed;
  logic [1:0] match_count;

  seq_detector_param #(
    .PAT_W       (8),
    .RST_PATTERN (8'b0000_1101),
    .RST_LEN     (4),
    .RST_OVERLAP (1'b1),
    .CNT_W       (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .din_valid   (din_valid),
    .din         (din),
    .match       (match),
    .armed       (armed),
    .match_count (match_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       m;
    logic       a;
    logic [1:0] c;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  bit         m_q[$];
  int         m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pat = 8'h0D;
    m_len = 4;
    m_ovl = 1'b1;
    m_q.delete();
    m_cnt = 0;
  endtask

  task automatic step(input logic ld, input logic [7:0] pat, input logic [3:0] len,
                      input logic ovl, input logic v, input logic d, input string tag);
    exp_t e;
    exp_t got;
    bit   hit;
    cfg_load    = ld;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    din_valid   = v;
    din         = d;
    e.m = 1'b0;
    if (ld) begin
      m_len = (int'(len) > 8) ? 8 : int'(len);
      m_pat = pat;
      m_ovl = ovl;
      m_q.delete();
      m_cnt = 0;
    end else if (v) begin
      m_q.push_back(d);
      if (m_q.size() > 16) void'(m_q.pop_front());
      hit = (m_len != 0) && (m_q.size() >= m_len);
      for (int i = 0; i < m_len && hit; i++)
        if (m_q[m_q.size()-1-i] != m_pat[i]) hit = 1'b0;
      if (hit) begin
        e.m = 1'b1;
        if (m_cnt < CNT_MAX) m_cnt++;
        if (!m_ovl) m_q.delete();
      end
    end
    e.a = (m_len != 0);
    e.c = CNT_ON ? 2'(m_cnt) : 2'd0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check({tag, ".match"}, 32'(match), 32'(got.m));
    check({tag, ".armed"}, 32'(armed), 32'(got.a));
    check({tag, ".count"}, 32'(match_count), 32'(got.c));
  endtask

  task automatic send(input logic v, input logic d, input string tag);
    step(1'b0, 8'h00, 4'd0, 1'b0, v, d, tag);
  endtask

  task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                      input logic v, input logic d, input string tag);
    step(1'b1, pat, len, ovl, v, d, tag);
  endtask

  initial begin
    logic [6:0] s1;
    logic [7:0] s5;
    rst_n = 1'b0;
    cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    din_valid = 1'b0; din = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.match", 32'(match), 32'd0);
    check("rst.armed", 32'(armed), 32'd1);
    check("rst.count", 32'(match_count), 32'd0);
    rst_n = 1'b1;
    model_reset();

    // Default overlapping 1101: hits after bits 4 and 7.
    s1 = 7'b1101101;
    for (int i = 6; i >= 0; i--) send(1'b1, s1[i], "t1");

    // Gaps between valid bits must not disturb history.
    load(8'h0D, 4'd4, 1'b1, 1'b0, 1'b0, "t3.load");
    s1 = 7'b0001101;
    for (int i = 3; i >= 0; i--) begin
      send(1'b1, s1[i], "t3.bit");
      repeat (3) send(1'b0, 1'b1, "t3.gap");
    end

    // Load in the same cycle as a valid bit discards that bit.
    s1 = 7'b0000110;
    for (int i = 2; i >= 0; i--) send(1'b1, s1[i], "t4.pre");
    load(8'h0D, 4'd4, 1'b1, 1'b1, 1'b1, "t4.load");
    s1 = 7'b0001101;
    for (int i = 3; i >= 0; i--) send(1'b1, s1[i], "t4.post");

    // Random valid/data mix on the default pattern.
    for (int i = 0; i < 40; i++)
      send(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), "rnd");

    // Pattern 11, non-overlapping then overlapping.
    load(8'h03, 4'd2, 1'b0, 1'b0, 1'b0, "t2.load0");
    repeat (4) send(1'b1, 1'b1, "t2.novl");
    load(8'h03, 4'd2, 1'b1, 1'b0, 1'b0, "t2.load1");
    repeat (4) send(1'b1, 1'b1, "t2.ovl");

    // Keep hitting until the 2-bit counter saturates, then reset mid-pulse.
    repeat (3) send(1'b1, 1'b1, "t6.sat");
    #2;
    rst_n = 1'b0;
    #1;
    check("t6.async.match", 32'(match), 32'd0);
    check("t6.async.armed", 32'(armed), 32'd1);
    check("t6.async.count", 32'(match_count), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    s1 = 7'b0001101;
    for (int i = 3; i >= 0; i--) send(1'b1, s1[i], "t6.post");

    // Zero length disarms; oversize length clamps to PAT_W.
    load(8'h0D, 4'd0, 1'b1, 1'b0, 1'b0, "t5.len0");
    for (int i = 3; i >= 0; i--) send(1'b1, s1[i], "t5.idle");
    repeat (4) send(1'b1, 1'b0, "t5.idle0");
    load(8'hA5, 4'd9, 1'b1, 1'b0, 1'b0, "t5.len9");
    s5 = 8'hA5;
    for (int i = 7; i >= 0; i--) send(1'b1, s5[i], "t5.a5");
    send(1'b0, 1'b0, "t5.tail");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
